vme_xcvr_sequencer: RTL

//  Sequences the external VME transceivers (address/LWORD and data banks, DTACK driver) on the VME64x slave.

---
 rtl/vme_xcvr_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/vme_xcvr_sequencer.sv
// vme_xcvr_sequencer: drives VME transceiver DIR/OE_N with break-before-make dead time
module vme_xcvr_sequencer #(
    parameter int g_DEAD_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic rnw_i,
    input  logic mblt_i,
    output logic ready_o,
    output logic busy_o,
    output logic addr_dir_o,
    output logic addr_oe_n_o,
    output logic data_dir_o,
    output logic data_oe_n_o,
    output logic dtack_oe_o
);
    typedef enum logic [2:0] {LISTEN, WR, RD_OFF, RD_TURN, DRIVE, REL_OFF, REL_TURN} state_t;
    localparam logic [3:0] LOAD = 4'(g_DEAD_CYCLES - 1);
    state_t     state;
    logic [3:0] cnt;
    logic       mblt_q;
    // Single FSM; every output is registered against the state being entered.
    // dtack_oe_o is left untouched on REL_OFF entry so it stays 1 after a
    // completed cycle and stays 0 after an aborted read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= LISTEN;
            cnt         <= '0;
            mblt_q      <= 1'b0;
            ready_o     <= 1'b0;
            busy_o      <= 1'b0;
            addr_dir_o  <= 1'b0;
            addr_oe_n_o <= 1'b0;
            data_dir_o  <= 1'b0;
            data_oe_n_o <= 1'b1;
            dtack_oe_o  <= 1'b0;
        end else begin
            case (state)
                LISTEN: begin
                    if (req_i) begin
                        busy_o <= 1'b1;
                        mblt_q <= rnw_i & mblt_i;
                        if (!rnw_i) begin
                            state       <= WR;
                            data_oe_n_o <= 1'b0;
                            ready_o     <= 1'b1;
                            dtack_oe_o  <= 1'b1;
                        end else begin
                            state       <= RD_OFF;
                            cnt         <= LOAD;
                            addr_oe_n_o <= mblt_i;
                        end
                    end
                end
                WR, DRIVE: begin
                    if (!req_i) begin
                        state       <= REL_OFF;
                        cnt         <= LOAD;
                        addr_oe_n_o <= 1'b1;
                        data_oe_n_o <= 1'b1;
                        ready_o     <= 1'b0;
                    end
                end
                RD_OFF: begin
                    if (!req_i) begin
                        state       <= REL_OFF;
                        cnt         <= LOAD;
                        addr_oe_n_o <= 1'b1;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= RD_TURN;
                        cnt        <= LOAD;
                        data_dir_o <= 1'b1;
                        addr_dir_o <= mblt_q;
                    end
                end
                RD_TURN: begin
                    if (!req_i) begin
                        state       <= REL_OFF;
                        cnt         <= LOAD;
                        addr_oe_n_o <= 1'b1;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state       <= DRIVE;
                        data_oe_n_o <= 1'b0;
                        addr_oe_n_o <= 1'b0;
                        ready_o     <= 1'b1;
                        dtack_oe_o  <= 1'b1;
                    end
                end
                REL_OFF: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= REL_TURN;
                        cnt        <= LOAD;
                        addr_dir_o <= 1'b0;
                        data_dir_o <= 1'b0;
                        dtack_oe_o <= 1'b0;
                    end
                end
                REL_TURN: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state       <= LISTEN;
                        addr_oe_n_o <= 1'b0;
                        busy_o      <= 1'b0;
                    end
                end
                default: state <= LISTEN;
            endcase
        end
    end
endmodule
